// File: rtl/stk_mc_pkg.sv
// Shared types for the multi-context linked-list stack engine.
// The module parameters take their defaults from the localparams below.
package stk_mc_pkg;

    localparam int STK_ENGS_N  = 4;
    localparam int STK_LINES_N = 64;
    localparam int STK_W       = 128;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_PEEK = 2'd3
    } opcode_t;

    typedef logic [$clog2(STK_ENGS_N)-1:0]    engid_t;
    typedef logic [$clog2(STK_LINES_N)-1:0]   ptr_t;
    typedef logic [$clog2(STK_LINES_N+1)-1:0] cnt_t;

    typedef struct packed {
        logic    vld;
        opcode_t opcode;
        logic    err;
    } rsp_hdr_t;

endpackage

// File: rtl/stk_mc_freelist.sv
// Shared line allocator: a free bitmap with lowest-index-first allocation and a
// registered count of free lines. Alloc and dealloc may happen in the same cycle.
module stk_mc_freelist
    import stk_mc_pkg::*;
#(
    parameter  int LINES_N = STK_LINES_N,
    localparam int PW      = $clog2(LINES_N),
    localparam int FW      = $clog2(LINES_N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc_i,
    output logic [PW-1:0] alloc_ptr_o,
    output logic          empty_o,
    input  logic          dealloc_i,
    input  logic [PW-1:0] dealloc_ptr_i,
    output logic [FW-1:0] free_cnt_o
);

    logic [LINES_N-1:0] free_q;
    logic [LINES_N-1:0] free_d;
    logic [FW-1:0]      cnt_q;
    logic [FW-1:0]      cnt_d;

    // Scanning downwards lets the lowest free index win.
    always_comb begin
        alloc_ptr_o = '0;
        for (int i = LINES_N - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                alloc_ptr_o = PW'(i);
            end
        end
    end

    assign empty_o    = ~|free_q;
    assign free_cnt_o = cnt_q;

    always_comb begin
        free_d = free_q;
        cnt_d  = cnt_q;
        if (alloc_i) begin
            free_d[alloc_ptr_o] = 1'b0;
            cnt_d               = cnt_d - FW'(1);
        end
        if (dealloc_i) begin
            free_d[dealloc_ptr_i] = 1'b1;
            cnt_d                 = cnt_d + FW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            free_q <= '1;
            cnt_q  <= FW'(LINES_N);
        end else begin
            free_q <= free_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/stk_mc_pipe.sv
// Multi-context stack engine: ENGS_N linked-list stacks over one shared line pool,
// with a round-robin admission stage, lookup, memory and registered response stages.
module stk_mc_pipe
    import stk_mc_pkg::*;
#(
    parameter  int ENGS_N  = STK_ENGS_N,
    parameter  int LINES_N = STK_LINES_N,
    parameter  int W       = STK_W,
    parameter  int CAP_N   = LINES_N,
    localparam int EW      = $clog2(ENGS_N),
    localparam int PW      = $clog2(LINES_N),
    localparam int CW      = $clog2(CAP_N + 1),
    localparam int FW      = $clog2(LINES_N + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ENGS_N-1:0]        i_cmd_vld,
    input  logic [ENGS_N-1:0][1:0]   i_cmd_opcode,
    input  logic [ENGS_N-1:0][W-1:0] i_cmd_dat,
    output logic [ENGS_N-1:0]        o_cmd_ack,
    output logic                     o_rsp_vld,
    output logic [EW-1:0]            o_rsp_engid,
    output logic [1:0]               o_rsp_opcode,
    output logic                     o_rsp_err,
    output logic [W-1:0]             o_rsp_dat,
    output logic [FW-1:0]            o_free_cnt
);

    // Admission stage
    logic [ENGS_N-1:0] elig;
    logic [ENGS_N-1:0] busy_q;
    logic [ENGS_N-1:0] busy_d;
    logic [EW-1:0]     rr_q;
    logic [EW-1:0]     rr_d;
    logic [EW:0]       cand;
    logic              gnt_vld;
    logic [EW-1:0]     gnt_idx;
    opcode_t           gnt_opc;

    // Lookup stage
    logic              lk_vld_q;
    logic [EW-1:0]     lk_eng_q;
    opcode_t           lk_opc_q;
    logic [W-1:0]      lk_dat_q;
    logic [PW-1:0]     lk_head;
    logic [CW-1:0]     lk_cnt;
    logic              lk_err;
    logic              alloc;
    logic              rd_en;
    logic [PW-1:0]     fl_ptr;
    logic              fl_empty;

    // Per-engine stack state and line storage
    logic [PW-1:0]     head_q [ENGS_N];
    logic [PW-1:0]     head_d [ENGS_N];
    logic [CW-1:0]     cnt_q  [ENGS_N];
    logic [CW-1:0]     cnt_d  [ENGS_N];
    logic [W-1:0]      data_ram [LINES_N];
    logic [PW-1:0]     next_ram [LINES_N];
    logic [W-1:0]      rd_data_q;
    logic [PW-1:0]     rd_next_q;

    // Memory stage
    logic              mem_vld_q;
    logic [EW-1:0]     mem_eng_q;
    opcode_t           mem_opc_q;
    logic              mem_err_q;
    logic [PW-1:0]     mem_ptr_q;
    logic              mem_pop_ok;

    // Response stage
    rsp_hdr_t          rsp_hdr_q;
    rsp_hdr_t          rsp_hdr_d;
    logic [EW-1:0]     rsp_eng_q;
    logic [EW-1:0]     rsp_eng_d;
    logic [W-1:0]      rsp_dat_q;
    logic [W-1:0]      rsp_dat_d;

    // Search starts at rr_q and wraps; the first eligible engine is granted.
    always_comb begin
        elig    = i_cmd_vld & ~busy_q & {ENGS_N{~rst}};
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < ENGS_N; i++) begin
            cand = {1'b0, rr_q} + (EW+1)'(i);
            if (cand >= (EW+1)'(ENGS_N)) begin
                cand = cand - (EW+1)'(ENGS_N);
            end
            if (!gnt_vld && elig[cand[EW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[EW-1:0];
            end
        end
    end

    assign gnt_opc = opcode_t'(i_cmd_opcode[gnt_idx]);

    always_comb begin
        o_cmd_ack = '0;
        if (gnt_vld) begin
            o_cmd_ack[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (gnt_vld) begin
            rr_d = (gnt_idx == EW'(ENGS_N - 1)) ? '0 : gnt_idx + EW'(1);
        end
    end

    // A POP blocks its engine until its head/cnt update lands at the end of MEM.
    always_comb begin
        busy_d = busy_q;
        if (gnt_vld && gnt_opc == OP_POP) begin
            busy_d[gnt_idx] = 1'b1;
        end
        if (mem_vld_q && mem_opc_q == OP_POP) begin
            busy_d[mem_eng_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q     <= '0;
            busy_q   <= '0;
            lk_vld_q <= 1'b0;
        end else begin
            rr_q     <= rr_d;
            busy_q   <= busy_d;
            lk_vld_q <= gnt_vld && (gnt_opc != OP_NOP);
        end
    end

    always_ff @(posedge clk) begin
        lk_eng_q <= gnt_idx;
        lk_opc_q <= gnt_opc;
        lk_dat_q <= i_cmd_dat[gnt_idx];
    end

    assign lk_head = head_q[lk_eng_q];
    assign lk_cnt  = cnt_q[lk_eng_q];

    always_comb begin
        lk_err = 1'b0;
        alloc  = 1'b0;
        rd_en  = 1'b0;
        if (lk_vld_q) begin
            case (lk_opc_q)
                OP_PUSH: begin
                    if (lk_cnt == CW'(CAP_N) || fl_empty) begin
                        lk_err = 1'b1;
                    end else begin
                        alloc = 1'b1;
                    end
                end
                OP_POP, OP_PEEK: begin
                    if (lk_cnt == '0) begin
                        lk_err = 1'b1;
                    end else begin
                        rd_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    stk_mc_freelist #(
        .LINES_N (LINES_N)
    ) u_freelist (
        .clk           (clk),
        .rst           (rst),
        .alloc_i       (alloc),
        .alloc_ptr_o   (fl_ptr),
        .empty_o       (fl_empty),
        .dealloc_i     (mem_pop_ok),
        .dealloc_ptr_i (mem_ptr_q),
        .free_cnt_o    (o_free_cnt)
    );

    // A new line links to the old head, so the chain is walked by POPs in LIFO order.
    always_ff @(posedge clk) begin
        if (alloc) begin
            data_ram[fl_ptr] <= lk_dat_q;
            next_ram[fl_ptr] <= lk_head;
        end
        if (rd_en) begin
            rd_data_q <= data_ram[lk_head];
            rd_next_q <= next_ram[lk_head];
        end
    end

    assign mem_pop_ok = mem_vld_q && (mem_opc_q == OP_POP) && !mem_err_q;

    always_comb begin
        head_d = head_q;
        cnt_d  = cnt_q;
        if (alloc) begin
            head_d[lk_eng_q] = fl_ptr;
            cnt_d[lk_eng_q]  = lk_cnt + CW'(1);
        end
        if (mem_pop_ok) begin
            head_d[mem_eng_q] = rd_next_q;
            cnt_d[mem_eng_q]  = cnt_q[mem_eng_q] - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        head_q <= head_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '{default: '0};
            mem_vld_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mem_vld_q <= lk_vld_q;
        end
    end

    always_ff @(posedge clk) begin
        mem_eng_q <= lk_eng_q;
        mem_opc_q <= lk_opc_q;
        mem_err_q <= lk_err;
        mem_ptr_q <= lk_head;
    end

    // Data is only returned for successful POP/PEEK; PUSH and errors answer with zero.
    always_comb begin
        rsp_hdr_d = '0;
        rsp_eng_d = '0;
        rsp_dat_d = '0;
        if (mem_vld_q) begin
            rsp_hdr_d.vld    = 1'b1;
            rsp_hdr_d.opcode = mem_opc_q;
            rsp_hdr_d.err    = mem_err_q;
            rsp_eng_d        = mem_eng_q;
            if (!mem_err_q && mem_opc_q != OP_PUSH) begin
                rsp_dat_d = rd_data_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_hdr_q <= '0;
            rsp_eng_q <= '0;
            rsp_dat_q <= '0;
        end else begin
            rsp_hdr_q <= rsp_hdr_d;
            rsp_eng_q <= rsp_eng_d;
            rsp_dat_q <= rsp_dat_d;
        end
    end

    assign o_rsp_vld    = rsp_hdr_q.vld;
    assign o_rsp_opcode = rsp_hdr_q.opcode;
    assign o_rsp_err    = rsp_hdr_q.err;
    assign o_rsp_engid  = rsp_eng_q;
    assign o_rsp_dat    = rsp_dat_q;

endmodule

// File: tb/tb_stk_mc_pipe.sv
// Bench for stk_mc_pipe: directed scripts plus random traffic, checked every cycle
// against per-engine queue stacks, a round-robin grant model and a free-line ledger.
module tb_stk_mc_pipe;
    import stk_mc_pkg::*;

    localparam int ENGS_N  = 4;
    localparam int LINES_N = 64;
    localparam int W       = 128;
    localparam int TB_CAP  = 20;
    localparam int EW      = $clog2(ENGS_N);
    localparam int FW      = $clog2(LINES_N + 1);

    logic                     clk;
    logic                     rst;
    logic [ENGS_N-1:0]        i_cmd_vld;
    logic [ENGS_N-1:0][1:0]   i_cmd_opcode;
    logic [ENGS_N-1:0][W-1:0] i_cmd_dat;
    logic [ENGS_N-1:0]        o_cmd_ack;
    logic                     o_rsp_vld;
    logic [EW-1:0]            o_rsp_engid;
    logic [1:0]               o_rsp_opcode;
    logic                     o_rsp_err;
    logic [W-1:0]             o_rsp_dat;
    logic [FW-1:0]            o_free_cnt;

    stk_mc_pipe #(
        .ENGS_N  (ENGS_N),
        .LINES_N (LINES_N),
        .W       (W),
        .CAP_N   (TB_CAP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_cmd_vld    (i_cmd_vld),
        .i_cmd_opcode (i_cmd_opcode),
        .i_cmd_dat    (i_cmd_dat),
        .o_cmd_ack    (o_cmd_ack),
        .o_rsp_vld    (o_rsp_vld),
        .o_rsp_engid  (o_rsp_engid),
        .o_rsp_opcode (o_rsp_opcode),
        .o_rsp_err    (o_rsp_err),
        .o_rsp_dat    (o_rsp_dat),
        .o_free_cnt   (o_free_cnt)
    );

    typedef struct {
        logic [1:0]   opc;
        logic [W-1:0] dat;
    } cmd_t;

    typedef struct {
        int           due;
        int           eng;
        logic [1:0]   opc;
        logic         err;
        logic [W-1:0] dat;
    } rsp_t;

    cmd_t         script [ENGS_N][$];
    logic [W-1:0] stk    [ENGS_N][$];
    rsp_t         rspQ   [$];
    int           freeDelta [int];

    bit           reqVld    [ENGS_N];
    logic [1:0]   reqOpc    [ENGS_N];
    logic [W-1:0] reqDat    [ENGS_N];
    int           busyUntil [ENGS_N];

    int cyc          = 0;
    int rrPtr        = 0;
    int expFree      = LINES_N;
    int lastPopOk    = -10;
    int checkCount   = 0;
    int failCount    = 0;
    bit rstReq       = 1'b1;
    bit randomMode   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [W-1:0] randData();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int linesHeld();
        int n = 0;
        for (int e = 0; e < ENGS_N; e++) n += stk[e].size();
        return n;
    endfunction

    function automatic bit workPending();
        bit p = (rspQ.size() != 0);
        for (int e = 0; e < ENGS_N; e++) begin
            if (reqVld[e] || script[e].size() != 0) p = 1'b1;
        end
        return p;
    endfunction

    task automatic addDelta(input int at, input int v);
        if (freeDelta.exists(at)) freeDelta[at] = freeDelta[at] + v;
        else freeDelta[at] = v;
    endtask

    task automatic addCmd(input int e, input logic [1:0] opc, input logic [W-1:0] dat);
        cmd_t c;
        c.opc = opc;
        c.dat = dat;
        script[e].push_back(c);
    endtask

    // Applies an accepted command to the stack model in ack order.
    task automatic modelCommand(input int g);
        rsp_t r;
        int   held;
        r.due = cyc + 3;
        r.eng = g;
        r.opc = reqOpc[g];
        r.err = 1'b0;
        r.dat = '0;
        case (reqOpc[g])
            OP_PUSH: begin
                held = linesHeld() + ((lastPopOk == cyc - 1) ? 1 : 0);
                if (stk[g].size() >= TB_CAP || held >= LINES_N) begin
                    r.err = 1'b1;
                end else begin
                    stk[g].push_back(reqDat[g]);
                    addDelta(cyc + 2, -1);
                end
            end
            OP_POP: begin
                if (stk[g].size() == 0) begin
                    r.err = 1'b1;
                end else begin
                    r.dat = stk[g].pop_back();
                    addDelta(cyc + 3, 1);
                    lastPopOk = cyc;
                end
                busyUntil[g] = cyc + 3;
            end
            OP_PEEK: begin
                if (stk[g].size() == 0) r.err = 1'b1;
                else r.dat = stk[g][$];
            end
            default: ;
        endcase
        if (reqOpc[g] != OP_NOP) rspQ.push_back(r);
    endtask

    // One clock cycle: drive requests, check grant, free count and response.
    task automatic applyStimulus();
        logic [ENGS_N-1:0] expAck;
        rsp_t r;
        int   g;
        int   pick;
        @(negedge clk);
        cyc++;
        rst = rstReq;
        for (int e = 0; e < ENGS_N; e++) begin
            if (rst) begin
                reqVld[e] = 1'b0;
            end else if (!reqVld[e]) begin
                if (script[e].size() != 0) begin
                    cmd_t c = script[e].pop_front();
                    reqVld[e] = 1'b1;
                    reqOpc[e] = c.opc;
                    reqDat[e] = c.dat;
                end else if (randomMode && $urandom_range(99) < 45) begin
                    pick      = int'($urandom_range(99));
                    reqVld[e] = 1'b1;
                    reqDat[e] = randData();
                    if (pick < 35)      reqOpc[e] = OP_PUSH;
                    else if (pick < 70) reqOpc[e] = OP_POP;
                    else if (pick < 85) reqOpc[e] = OP_PEEK;
                    else                reqOpc[e] = OP_NOP;
                end
            end
            i_cmd_vld[e]    = reqVld[e];
            i_cmd_opcode[e] = reqOpc[e];
            i_cmd_dat[e]    = reqDat[e];
        end
        #1;
        g = -1;
        if (!rst) begin
            for (int k = 0; k < ENGS_N; k++) begin
                int e;
                e = (rrPtr + k) % ENGS_N;
                if (g < 0 && reqVld[e] && cyc >= busyUntil[e]) g = e;
            end
        end
        expAck = '0;
        if (g >= 0) expAck[g] = 1'b1;
        checkOutput("ack", W'(o_cmd_ack), W'(expAck));

        if (freeDelta.exists(cyc)) begin
            expFree = expFree + freeDelta[cyc];
            freeDelta.delete(cyc);
        end
        checkOutput("freeCnt", W'(o_free_cnt), W'(expFree));

        if (rspQ.size() != 0 && rspQ[0].due == cyc) begin
            r = rspQ.pop_front();
            checkOutput("rspVld", W'(o_rsp_vld), W'(1));
            checkOutput("rspEngid", W'(o_rsp_engid), W'(r.eng));
            checkOutput("rspOpcode", W'(o_rsp_opcode), W'(r.opc));
            checkOutput("rspErr", W'(o_rsp_err), W'(r.err));
            checkOutput("rspDat", o_rsp_dat, r.dat);
        end else begin
            checkOutput("rspVld", W'(o_rsp_vld), W'(0));
        end

        if (g >= 0) begin
            modelCommand(g);
            reqVld[g] = 1'b0;
            rrPtr     = (g + 1) % ENGS_N;
        end

        if (rst) begin
            for (int e = 0; e < ENGS_N; e++) begin
                stk[e].delete();
                busyUntil[e] = 0;
            end
            rrPtr     = 0;
            lastPopOk = -10;
            expFree   = LINES_N;
            freeDelta.delete();
            while (rspQ.size() != 0 && rspQ[$].due > cyc) void'(rspQ.pop_back());
        end
    endtask

    task automatic doReset(input int n);
        rstReq = 1'b1;
        repeat (n) applyStimulus();
        rstReq = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (workPending() && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput("drainDone", W'(workPending()), W'(0));
        repeat (4) applyStimulus();
    endtask

    initial begin
        rst          = 1'b1;
        i_cmd_vld    = '0;
        i_cmd_opcode = '0;
        i_cmd_dat    = '0;
        for (int e = 0; e < ENGS_N; e++) begin
            reqVld[e]    = 1'b0;
            reqOpc[e]    = OP_NOP;
            reqDat[e]    = '0;
            busyUntil[e] = 0;
        end

        doReset(3);

        addCmd(0, OP_PUSH, W'(8'hA5));
        drain(50);

        addCmd(1, OP_PUSH, W'(1));
        addCmd(1, OP_PUSH, W'(2));
        addCmd(1, OP_PUSH, W'(3));
        addCmd(1, OP_PEEK, '0);
        repeat (4) addCmd(1, OP_POP, '0);
        drain(100);

        for (int e = 0; e < ENGS_N; e++) begin
            addCmd(e, OP_PUSH, randData());
            addCmd(e, OP_PUSH, randData());
        end
        drain(100);

        addCmd(0, OP_POP, '0);
        addCmd(0, OP_PUSH, W'(16'h0077));
        addCmd(1, OP_NOP, '0);
        addCmd(1, OP_PUSH, W'(16'h1111));
        addCmd(1, OP_PUSH, W'(16'h2222));
        drain(100);

        doReset(2);
        for (int i = 1; i <= TB_CAP + 1; i++) addCmd(2, OP_PUSH, W'(i));
        addCmd(2, OP_POP, '0);
        drain(200);

        doReset(2);
        for (int i = 0; i < 17; i++) begin
            for (int e = 0; e < ENGS_N; e++) addCmd(e, OP_PUSH, randData());
        end
        drain(300);

        randomMode = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) doReset(2);
            else applyStimulus();
        end
        randomMode = 1'b0;
        drain(200);

        addCmd(0, OP_PUSH, randData());
        addCmd(1, OP_PUSH, randData());
        repeat (2) applyStimulus();
        doReset(2);
        for (int e = 0; e < ENGS_N; e++) addCmd(e, OP_POP, '0);
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
